// File: rtl/rnd_hex_pkg.sv
// Shared constants and helpers for the random hex value source.
//   LFSR_MASK     - feedback taps of the 16-bit Galois LFSR (maximal length)
//   DEFAULT_SEED  - LFSR start value used when no seed is supplied
//   IDLE / ROLL   - FSM state encoding
//   lfsr_step     - one Galois shift of the LFSR
//   seed_fix      - maps the forbidden all-zero seed onto 16'h0001
package rnd_hex_pkg;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ROLL = 1'b1;

    typedef logic [15:0] hex_word_t;

    function automatic hex_word_t lfsr_step(input hex_word_t v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // All-zero is the LFSR lock-up state, so it can never be a start value.
    function automatic hex_word_t seed_fix(input hex_word_t s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/rnd_hex_source_if.sv
// Output bundle of rnd_hex_source towards the hex display.
//   o_data    - 16-bit value to show
//   o_valid   - one-cycle pulse when a final value is latched
//   o_rolling - high while the value is rolling
// master: the source drives the bundle; slave: the display observes it.
interface rnd_hex_source_if;

    logic [15:0] o_data;
    logic        o_valid;
    logic        o_rolling;

    modport master (output o_data, o_valid, o_rolling);
    modport slave  (input  o_data, o_valid, o_rolling);

endinterface

// File: rtl/rnd_hex_source_btn_debounce.sv
// Push-button conditioning: two-flop synchroniser, debounce counter and
// registered one-cycle edge pulses.
//   clk, rst - clock and synchronous active-high reset
//   i_raw    - raw button, asynchronous to clk
//   o_level  - debounced button level
//   o_rise   - one-cycle pulse one cycle after o_level rises
//   o_fall   - one-cycle pulse one cycle after o_level falls
// The level only flips after the synchronised input has disagreed with it
// for 2**DEB_WIDTH consecutive cycles; any shorter disagreement is dropped.
module btn_debounce #(
    parameter int DEB_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0]           sync_reg;
    logic                 btn_s;
    logic [DEB_WIDTH-1:0] deb_cnt_reg;
    logic                 stable_reg;
    logic                 stable_d_reg;
    logic                 rise_reg;
    logic                 fall_reg;

    assign btn_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg     <= 2'b00;
            deb_cnt_reg  <= '0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], i_raw};

            if (btn_s == stable_reg) begin
                deb_cnt_reg <= '0;
            end else if (&deb_cnt_reg) begin
                stable_reg  <= btn_s;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end

            // Edges come from comparing the level with its own delayed copy,
            // so each pulse is exactly one cycle wide and fully registered.
            stable_d_reg <= stable_reg;
            rise_reg     <= stable_reg & ~stable_d_reg;
            fall_reg     <= ~stable_reg & stable_d_reg;
        end
    end

    assign o_level = stable_reg;
    assign o_rise  = rise_reg;
    assign o_fall  = fall_reg;

endmodule

// File: rtl/rnd_hex_source.sv
// Random value source for the 4-digit hex display.
//   clk, rst - clock and synchronous active-high reset
//   i_btn    - raw push-button (asynchronous, active-high)
//   out_if   - master side of rnd_hex_source_if (o_data, o_valid, o_rolling)
// A free-running Galois LFSR advances every cycle. While the debounced button
// is held the displayed value reloads from the LFSR every 2**ROLL_SHIFT
// cycles; on release the current LFSR value is latched, held and flagged
// with a one-cycle o_valid pulse.
module rnd_hex_source
    import rnd_hex_pkg::*;
#(
    parameter int          DEB_WIDTH  = 16,
    parameter int          ROLL_SHIFT = 20,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_btn,
    rnd_hex_source_if.master out_if
);

    localparam hex_word_t SEED_EFF = seed_fix(SEED);

    logic                  btn_level;
    logic                  btn_rise;
    logic                  btn_fall;

    hex_word_t             lfsr_reg;
    hex_word_t             data_reg;
    logic [0:0]            state_reg;
    logic [ROLL_SHIFT-1:0] roll_cnt_reg;
    logic                  valid_reg;
    logic                  rolling_reg;
    logic                  roll_tick;

    btn_debounce #(
        .DEB_WIDTH (DEB_WIDTH)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (i_btn),
        .o_level (btn_level),
        .o_rise  (btn_rise),
        .o_fall  (btn_fall)
    );

    assign roll_tick = &roll_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg     <= SEED_EFF;
            data_reg     <= 16'h0000;
            state_reg    <= IDLE;
            roll_cnt_reg <= '0;
            valid_reg    <= 1'b0;
            rolling_reg  <= 1'b0;
        end else begin
            lfsr_reg  <= lfsr_step(lfsr_reg);
            valid_reg <= 1'b0;

            // Edge pulses are qualified with the level they describe; the
            // level cannot flip back within one debounce period, so this
            // never masks a genuine edge.
            case (state_reg)
                IDLE: begin
                    if (btn_rise && btn_level) begin
                        state_reg    <= ROLL;
                        rolling_reg  <= 1'b1;
                        data_reg     <= lfsr_reg;
                        roll_cnt_reg <= '0;
                    end
                end
                ROLL: begin
                    // Release wins over a coincident roll tick: one load,
                    // and the valid pulse is still produced.
                    if (btn_fall && !btn_level) begin
                        state_reg   <= IDLE;
                        rolling_reg <= 1'b0;
                        data_reg    <= lfsr_reg;
                        valid_reg   <= 1'b1;
                    end else begin
                        roll_cnt_reg <= roll_cnt_reg + 1'b1;
                        if (roll_tick) begin
                            data_reg <= lfsr_reg;
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    rolling_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.o_data    = data_reg;
    assign out_if.o_valid   = valid_reg;
    assign out_if.o_rolling = rolling_reg;

endmodule
